regfile_access_ctrl: RTL and testbench

//  Host-side initiator for the banked 10-bit register file (2 banks x 4 regs).

---
 rtl/regfile_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Host-side command initiator for the banked register file: sequences one
// write or dual-port read at a time, returns one response each and counts them.
module regfile_access_ctrl #(
  parameter int DW         = 10,
  parameter int AW         = 2,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic          cmd_bank,
  input  logic [AW-1:0] cmd_addr1,
  input  logic [AW-1:0] cmd_addr2,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_data1,
  output logic [DW-1:0] rsp_data2,
  output logic          rf_we,
  output logic          rf_bank_sel,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          busy,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_write_q, rsp_write_d;
  logic [DW-1:0] rsp_data1_q, rsp_data1_d;
  logic [DW-1:0] rsp_data2_q, rsp_data2_d;
  logic       rf_we_q, rf_we_d;
  logic       rf_bank_sel_q, rf_bank_sel_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [AW-1:0] rf_raddr1_q, rf_raddr1_d;
  logic [AW-1:0] rf_raddr2_q, rf_raddr2_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // Every output is a flop; the next values are all decided here so the
  // outputs line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    cmd_ready_d   = cmd_ready_q;
    busy_d        = busy_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_data1_d   = rsp_data1_q;
    rsp_data2_d   = rsp_data2_q;
    rf_we_d       = 1'b0;
    rf_bank_sel_d = rf_bank_sel_q;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    rf_raddr1_d   = rf_raddr1_q;
    rf_raddr2_d   = rf_raddr2_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d   = 1'b0;
          busy_d        = 1'b1;
          rf_bank_sel_d = cmd_bank;
          if (cmd_write) begin
            rf_waddr_d = cmd_addr1;
            rf_wdata_d = cmd_wdata;
            rf_we_d    = 1'b1;
            state_d    = WR;
          end else begin
            rf_raddr1_d = cmd_addr1;
            rf_raddr2_d = cmd_addr2;
            state_d     = RD;
          end
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_data1_d = '0;
        rsp_data2_d = '0;
        state_d     = RSP;
      end
      RD: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Capture on the last wait cycle, when the file's registered data is valid.
        if (wait_q == LAT_M1) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data1_d = rf_rdata1;
          rsp_data2_d = rf_rdata2;
          state_d     = RSP;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
          if (rsp_write_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          else             rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_data1_q   <= '0;
      rsp_data2_q   <= '0;
      rf_we_q       <= 1'b0;
      rf_bank_sel_q <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_raddr1_q   <= '0;
      rf_raddr2_q   <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_data1_q   <= rsp_data1_d;
      rsp_data2_q   <= rsp_data2_d;
      rf_we_q       <= rf_we_d;
      rf_bank_sel_q <= rf_bank_sel_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_raddr1_q   <= rf_raddr1_d;
      rf_raddr2_q   <= rf_raddr2_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_data1   = rsp_data1_q;
  assign rsp_data2   = rsp_data2_q;
  assign rf_we       = rf_we_q;
  assign rf_bank_sel = rf_bank_sel_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_raddr1   = rf_raddr1_q;
  assign rf_raddr2   = rf_raddr2_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 2x4 register file
// (registered read data, updated only while we=0) attached to the rf_* pins.
module tb_regfile_access_ctrl;
  localparam int DW = 10;
  localparam int AW = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write, cmd_bank;
  logic [AW-1:0] cmd_addr1, cmd_addr2;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic rf_we, rf_bank_sel;
  logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic busy;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DW(DW), .AW(AW), .RD_LATENCY(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_we(rf_we), .rf_bank_sel(rf_bank_sel), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  // Register file the controller talks to; read latency of one cycle.
  logic [DW-1:0] mem [2][4];
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++) mem[b][r] <= '0;
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else if (rf_we) begin
      mem[rf_bank_sel][rf_waddr] <= rf_wdata;
    end else begin
      rf_rdata1 <= mem[rf_bank_sel][rf_raddr1];
      rf_rdata2 <= mem[rf_bank_sel][rf_raddr2];
    end
  end

  // Caller is at a negedge with cmd_ready high; returns at the next negedge (cycle N+1).
  task automatic send_cmd(input logic wr, input logic bank, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_bank  = bank;
    cmd_addr1 = a1;
    cmd_addr2 = a2;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts cycles from accept until rsp_valid, bounded.
  task automatic wait_rsp(output int cycles, output bit timeout);
    cycles  = 1;
    timeout = 1'b0;
    while (!rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!rsp_valid) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rf_we got %0b exp 0", rf_we); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    tests_run++; if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt got wr=%0d rd=%0d exp 0/0", wr_cnt, rd_cnt); end
  endtask

  task automatic test_write();
    int cyc; bit to;
    send_cmd(1'b1, 1'b0, 2'd1, 2'd0, 10'd55);
    tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_we_pulse got %0b exp 1", rf_we); end
    tests_run++; if (rf_waddr !== 2'd1 || rf_wdata !== 10'd55 || rf_bank_sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_pins got a=%0d d=%0d b=%0d exp 1/55/0", rf_waddr, rf_wdata, rf_bank_sel); end
    tests_run++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_busy got busy=%0b rdy=%0b exp 1/0", busy, cmd_ready); end
    wait_rsp(cyc, to);
    tests_run++; if (to || cyc != 2) begin tests_failed++; $display("[TB] FAIL wr_ack_latency got %0d exp 2", cyc); end
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_we_one_cycle got %0b exp 0", rf_we); end
    tests_run++; if (rsp_write !== 1'b1 || rsp_data1 !== 10'd0 || rsp_data2 !== 10'd0) begin tests_failed++; $display("[TB] FAIL wr_ack_fields got w=%0b d1=%0d d2=%0d exp 1/0/0", rsp_write, rsp_data1, rsp_data2); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_handshake got v=%0b rdy=%0b exp 0/1", rsp_valid, cmd_ready); end
    tests_run++; if (wr_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL wr_cnt got %0d exp 1", wr_cnt); end
  endtask

  task automatic test_read();
    int cyc; bit to;
    send_cmd(1'b1, 1'b1, 2'd2, 2'd0, 10'd100); wait_rsp(cyc, to); @(negedge clk);
    send_cmd(1'b1, 1'b1, 2'd0, 2'd0, 10'd150); wait_rsp(cyc, to); @(negedge clk);
    send_cmd(1'b0, 1'b1, 2'd2, 2'd0, 10'd0);
    tests_run++; if (rf_we !== 1'b0 || rf_raddr1 !== 2'd2 || rf_raddr2 !== 2'd0 || rf_bank_sel !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_pins got we=%0b a1=%0d a2=%0d b=%0d exp 0/2/0/1", rf_we, rf_raddr1, rf_raddr2, rf_bank_sel); end
    wait_rsp(cyc, to);
    tests_run++; if (to || cyc != 3) begin tests_failed++; $display("[TB] FAIL rd_latency got %0d exp 3", cyc); end
    tests_run++; if (rsp_write !== 1'b0 || rsp_data1 !== 10'd100 || rsp_data2 !== 10'd150) begin tests_failed++; $display("[TB] FAIL rd_data got w=%0b d1=%0d d2=%0d exp 0/100/150", rsp_write, rsp_data1, rsp_data2); end
    @(negedge clk);
    tests_run++; if (rd_cnt !== 8'd1 || wr_cnt !== 8'd3) begin tests_failed++; $display("[TB] FAIL rd_cnts got wr=%0d rd=%0d exp 3/1", wr_cnt, rd_cnt); end
  endtask

  task automatic test_bank_isolation();
    int cyc; bit to;
    send_cmd(1'b0, 1'b0, 2'd2, 2'd1, 10'd0);
    wait_rsp(cyc, to);
    tests_run++; if (to || rsp_data1 !== 10'd0 || rsp_data2 !== 10'd55) begin tests_failed++; $display("[TB] FAIL bank_iso got d1=%0d d2=%0d to=%0b exp 0/55/0", rsp_data1, rsp_data2, to); end
    @(negedge clk);
    tests_run++; if (rd_cnt !== 8'd2) begin tests_failed++; $display("[TB] FAIL bank_iso_cnt got %0d exp 2", rd_cnt); end
  endtask

  task automatic test_backpressure();
    int cyc; bit to;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 1'b1, 2'd0, 2'd2, 10'd0);
    wait_rsp(cyc, to);
    tests_run++; if (to || rsp_data1 !== 10'd150 || rsp_data2 !== 10'd100) begin tests_failed++; $display("[TB] FAIL bp_data got d1=%0d d2=%0d exp 150/100", rsp_data1, rsp_data2); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_bank = 1'b1; cmd_addr1 = 2'd3; cmd_wdata = 10'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b1 || rsp_data1 !== 10'd150 || rsp_data2 !== 10'd100 || cmd_ready !== 1'b0 || rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_hold cycle %0d got v=%0b d1=%0d d2=%0d rdy=%0b we=%0b exp 1/150/100/0/0", i, rsp_valid, rsp_data1, rsp_data2, cmd_ready, rf_we); end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release got v=%0b rdy=%0b exp 0/1", rsp_valid, cmd_ready); end
    @(negedge clk);
    tests_run++; if (rd_cnt !== 8'd3 || wr_cnt !== 8'd3) begin tests_failed++; $display("[TB] FAIL bp_cnt got wr=%0d rd=%0d exp 3/3", wr_cnt, rd_cnt); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    send_cmd(1'b0, 1'b1, 2'd2, 2'd0, 10'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_idle got busy=%0b rdy=%0b v=%0b exp 0/1/0", busy, cmd_ready, rsp_valid); end
    tests_run++; if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL rst_wait_cnt got wr=%0d rd=%0d exp 0/0", wr_cnt, rd_cnt); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("[TB] FAIL rst_wait_no_rsp got %0d responses exp 0", seen); end
  endtask

  task automatic test_wr_cnt_wrap();
    int cyc; bit to;
    int timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      send_cmd(1'b1, i[0], i[1:0], 2'd0, i[9:0]);
      wait_rsp(cyc, to);
      if (to) timeouts++;
      @(negedge clk);
      if (i == 254) begin
        tests_run++; if (wr_cnt !== 8'd255) begin tests_failed++; $display("[TB] FAIL wrap_255 got %0d exp 255", wr_cnt); end
      end
    end
    tests_run++; if (timeouts != 0) begin tests_failed++; $display("[TB] FAIL wrap_timeouts got %0d exp 0", timeouts); end
    tests_run++; if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL wrap_cnt got wr=%0d rd=%0d exp 0/0", wr_cnt, rd_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = 1'b0;
    cmd_addr1 = '0; cmd_addr2 = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_bank_isolation();
    test_backpressure();
    test_reset_in_wait();
    test_wr_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
